// File: rtl/tt_vpu_lq_pkg.sv
// Shared types for the vector load-return queue: per-entry state and VREG index width.
package tt_vpu_lq_pkg;

  localparam int VREG_W = 5;

  typedef enum logic [1:0] {
    LQ_EMPTY  = 2'b00,
    LQ_ALLOC  = 2'b01,
    LQ_FILLED = 2'b10
  } lq_state_t;

endpackage

// File: rtl/tt_vpu_lq_entry.sv
// One load-queue slot: EMPTY/ALLOC/FILLED state plus vd/last/data/mask storage.
module tt_vpu_lq_entry
  import tt_vpu_lq_pkg::*;
#(
  parameter int DATA_W = 512,
  parameter int MASK_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              alloc,
  input  logic [VREG_W-1:0] alloc_vd,
  input  logic              alloc_last,
  input  logic              fill,
  input  logic [DATA_W-1:0] fill_data,
  input  logic [MASK_W-1:0] fill_mask,
  input  logic              retire,
  output lq_state_t         state,
  output logic [VREG_W-1:0] vd,
  output logic              last,
  output logic [DATA_W-1:0] data,
  output logic [MASK_W-1:0] mask
);

  logic take_alloc, take_fill;

  assign take_alloc = !flush && alloc && (state == LQ_EMPTY);
  assign take_fill  = !flush && fill  && (state == LQ_ALLOC);

  // Retire wins over fill so a bypassed head fill never lingers as FILLED.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             state <= LQ_EMPTY;
    else if (flush)      state <= LQ_EMPTY;
    else if (retire)     state <= LQ_EMPTY;
    else if (take_fill)  state <= LQ_FILLED;
    else if (take_alloc) state <= LQ_ALLOC;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vd   <= '0;
      last <= 1'b0;
      data <= '0;
      mask <= '0;
    end else begin
      if (take_alloc) begin
        vd   <= alloc_vd;
        last <= alloc_last;
      end
      if (take_fill) begin
        data <= fill_data;
        mask <= fill_mask;
      end
    end
  end

endmodule

// File: rtl/tt_vpu_load_queue.sv
// In-order load-return queue: out-of-order fills by index, in-order writeback to the VRF.
// Optional same-cycle head-fill bypass is enabled by defining TT_VPU_LQ_BYPASS_EN.
module tt_vpu_load_queue
  import tt_vpu_lq_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 512,
  parameter int MASK_W = DATA_W / 8,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_flush,
  input  logic              i_alloc_valid,
  output logic              o_alloc_ready,
  input  logic [VREG_W-1:0] i_alloc_vd,
  input  logic              i_alloc_last,
  output logic [IDX_W-1:0]  o_alloc_idx,
  input  logic              i_ld_valid,
  input  logic [IDX_W-1:0]  i_ld_idx,
  input  logic [DATA_W-1:0] i_ld_data,
  input  logic [MASK_W-1:0] i_ld_mask,
  output logic              o_wb_valid,
  input  logic              i_wb_ready,
  output logic [VREG_W-1:0] o_wb_vd,
  output logic [DATA_W-1:0] o_wb_data,
  output logic [MASK_W-1:0] o_wb_mask,
  output logic              o_wb_last,
  output logic              o_lq_empty,
  output logic [IDX_W:0]    o_count,
  output logic              o_err
);

  logic [IDX_W-1:0] head, tail;
  logic [IDX_W:0]   count;
  logic             err;

  lq_state_t                     ent_state [DEPTH];
  logic [DEPTH-1:0][VREG_W-1:0]  ent_vd;
  logic [DEPTH-1:0]              ent_last;
  logic [DEPTH-1:0][DATA_W-1:0]  ent_data;
  logic [DEPTH-1:0][MASK_W-1:0]  ent_mask;

  logic alloc_fire, retire, head_filled, bypass_hit, bad_fill;

  assign o_alloc_ready = (count != (IDX_W+1)'(DEPTH));
  assign alloc_fire    = i_alloc_valid && o_alloc_ready && !i_flush;
  assign head_filled   = (ent_state[head] == LQ_FILLED);
  assign bad_fill      = i_ld_valid && !i_flush && (ent_state[i_ld_idx] != LQ_ALLOC);

`ifdef TT_VPU_LQ_BYPASS_EN
  assign bypass_hit = i_ld_valid && !i_flush && (i_ld_idx == head) &&
                      (ent_state[head] == LQ_ALLOC);
`else
  assign bypass_hit = 1'b0;
`endif

  assign o_wb_valid = head_filled || bypass_hit;
  assign retire     = o_wb_valid && i_wb_ready && !i_flush;

  assign o_wb_vd    = ent_vd[head];
  assign o_wb_last  = ent_last[head];
  assign o_wb_data  = bypass_hit ? i_ld_data : ent_data[head];
  assign o_wb_mask  = bypass_hit ? i_ld_mask : ent_mask[head];

  assign o_alloc_idx = tail;
  assign o_lq_empty  = (count == '0);
  assign o_count     = count;
  assign o_err       = err;

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    tt_vpu_lq_entry #(
      .DATA_W (DATA_W),
      .MASK_W (MASK_W)
    ) u_ent (
      .clk        (i_clk),
      .rst        (i_reset),
      .flush      (i_flush),
      .alloc      (alloc_fire && (tail == IDX_W'(g))),
      .alloc_vd   (i_alloc_vd),
      .alloc_last (i_alloc_last),
      .fill       (i_ld_valid && (i_ld_idx == IDX_W'(g))),
      .fill_data  (i_ld_data),
      .fill_mask  (i_ld_mask),
      .retire     (retire && (head == IDX_W'(g))),
      .state      (ent_state[g]),
      .vd         (ent_vd[g]),
      .last       (ent_last[g]),
      .data       (ent_data[g]),
      .mask       (ent_mask[g])
    );
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (i_flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (alloc_fire) tail <= tail + 1'b1;
      if (retire)     head <= head + 1'b1;
      case ({alloc_fire, retire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)       err <= 1'b0;
    else if (bad_fill) err <= 1'b1;
  end

endmodule

// File: tb/tb_tt_vpu_load_queue.sv
// Directed self-checking bench for tt_vpu_load_queue (DEPTH=8, DATA_W=512).
module tb_tt_vpu_load_queue;

  localparam int DEPTH  = 8;
  localparam int DATA_W = 512;
  localparam int MASK_W = 64;
  localparam int IDX_W  = 3;

  logic              i_clk = 1'b0;
  logic              i_reset = 1'b0;
  logic              i_flush = 1'b0;
  logic              i_alloc_valid = 1'b0;
  logic              o_alloc_ready;
  logic [4:0]        i_alloc_vd = '0;
  logic              i_alloc_last = 1'b0;
  logic [IDX_W-1:0]  o_alloc_idx;
  logic              i_ld_valid = 1'b0;
  logic [IDX_W-1:0]  i_ld_idx = '0;
  logic [DATA_W-1:0] i_ld_data = '0;
  logic [MASK_W-1:0] i_ld_mask = '0;
  logic              o_wb_valid;
  logic              i_wb_ready = 1'b0;
  logic [4:0]        o_wb_vd;
  logic [DATA_W-1:0] o_wb_data;
  logic [MASK_W-1:0] o_wb_mask;
  logic              o_wb_last;
  logic              o_lq_empty;
  logic [IDX_W:0]    o_count;
  logic              o_err;

  int checks = 0;
  int passes = 0;

  tt_vpu_load_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .MASK_W(MASK_W), .IDX_W(IDX_W)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_flush(i_flush),
    .i_alloc_valid(i_alloc_valid), .o_alloc_ready(o_alloc_ready),
    .i_alloc_vd(i_alloc_vd), .i_alloc_last(i_alloc_last), .o_alloc_idx(o_alloc_idx),
    .i_ld_valid(i_ld_valid), .i_ld_idx(i_ld_idx), .i_ld_data(i_ld_data), .i_ld_mask(i_ld_mask),
    .o_wb_valid(o_wb_valid), .i_wb_ready(i_wb_ready), .o_wb_vd(o_wb_vd),
    .o_wb_data(o_wb_data), .o_wb_mask(o_wb_mask), .o_wb_last(o_wb_last),
    .o_lq_empty(o_lq_empty), .o_count(o_count), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [DATA_W-1:0] mkd(input int k);
    logic [31:0] w;
    w = 32'h5A5A_0000 + 32'(k);
    return {16{w}};
  endfunction

  function automatic logic [MASK_W-1:0] mkm(input int k);
    logic [7:0] b;
    b = 8'(k) ^ 8'hC3;
    return {8{b}};
  endfunction

  task automatic step();
    @(posedge i_clk);
    #2;
  endtask

  task automatic idle();
    i_flush = 0; i_alloc_valid = 0; i_ld_valid = 0; i_wb_ready = 0;
  endtask

  task automatic do_reset();
    idle();
    i_reset = 1;
    step();
    i_reset = 0;
  endtask

  task automatic alloc1(input int vd, input bit last);
    i_alloc_valid = 1; i_alloc_vd = 5'(vd); i_alloc_last = last;
    step();
    i_alloc_valid = 0;
  endtask

  task automatic fill1(input int idx, input int k);
    i_ld_valid = 1; i_ld_idx = IDX_W'(idx); i_ld_data = mkd(k); i_ld_mask = mkm(k);
    step();
    i_ld_valid = 0;
  endtask

  task automatic test_reset();
    idle();
    i_reset = 1;
    #1;
    checks++; if (o_alloc_ready !== 1'b1) $display("FAIL rst_ready got=%b want=1", o_alloc_ready); else passes++;
    checks++; if (o_wb_valid !== 1'b0) $display("FAIL rst_wb_valid got=%b want=0", o_wb_valid); else passes++;
    checks++; if (o_lq_empty !== 1'b1) $display("FAIL rst_empty got=%b want=1", o_lq_empty); else passes++;
    checks++; if (o_count !== 4'd0) $display("FAIL rst_count got=%0d want=0", o_count); else passes++;
    checks++; if (o_err !== 1'b0) $display("FAIL rst_err got=%b want=0", o_err); else passes++;
    checks++; if (o_alloc_idx !== 3'd0) $display("FAIL rst_idx got=%0d want=0", o_alloc_idx); else passes++;
    checks++; if ({o_wb_vd, o_wb_last, o_wb_mask} !== '0 || o_wb_data !== '0)
      $display("FAIL rst_wb_fields got vd=%0d last=%b mask=%0h want all 0", o_wb_vd, o_wb_last, o_wb_mask); else passes++;
    step();
    i_reset = 0;
  endtask

  task automatic test_in_order();
    do_reset();
    alloc1(1, 0);
    checks++; if (o_alloc_idx !== 3'd1) $display("FAIL io_idx1 got=%0d want=1", o_alloc_idx); else passes++;
    alloc1(2, 0);
    alloc1(3, 1);
    checks++; if (o_count !== 4'd3) $display("FAIL io_count3 got=%0d want=3", o_count); else passes++;
    fill1(2, 3);
    checks++; if (o_wb_valid !== 1'b0) $display("FAIL io_no_wb_yet got=%b want=0", o_wb_valid); else passes++;
    fill1(0, 1);
    fill1(1, 2);
    i_wb_ready = 1;
    #1;
    checks++; if (o_wb_valid !== 1 || o_wb_vd !== 5'd1 || o_wb_data !== mkd(1) || o_wb_last !== 0)
      $display("FAIL io_wb0 got v=%b vd=%0d last=%b want v=1 vd=1 last=0", o_wb_valid, o_wb_vd, o_wb_last); else passes++;
    step(); #1;
    checks++; if (o_wb_valid !== 1 || o_wb_vd !== 5'd2 || o_wb_data !== mkd(2) || o_wb_mask !== mkm(2) || o_wb_last !== 0)
      $display("FAIL io_wb1 got v=%b vd=%0d last=%b want v=1 vd=2 last=0", o_wb_valid, o_wb_vd, o_wb_last); else passes++;
    step(); #1;
    checks++; if (o_wb_valid !== 1 || o_wb_vd !== 5'd3 || o_wb_data !== mkd(3) || o_wb_last !== 1 || o_lq_empty !== 0)
      $display("FAIL io_wb2 got v=%b vd=%0d last=%b empty=%b want v=1 vd=3 last=1 empty=0", o_wb_valid, o_wb_vd, o_wb_last, o_lq_empty); else passes++;
    step();
    i_wb_ready = 0;
    checks++; if (o_lq_empty !== 1 || o_wb_valid !== 0 || o_count !== 4'd0)
      $display("FAIL io_drained got empty=%b v=%b cnt=%0d want 1 0 0", o_lq_empty, o_wb_valid, o_count); else passes++;
  endtask

  task automatic test_full();
    do_reset();
    i_alloc_valid = 1;
    for (int i = 0; i < DEPTH; i++) begin
      i_alloc_vd = 5'(i + 8); i_alloc_last = 0;
      step();
    end
    #1;
    checks++; if (o_alloc_ready !== 0 || o_count !== 4'd8)
      $display("FAIL full_state got ready=%b cnt=%0d want 0 8", o_alloc_ready, o_count); else passes++;
    i_alloc_vd = 5'd20;
    fill1(0, 5);
    i_wb_ready = 1;
    #1;
    checks++; if (o_wb_valid !== 1 || o_alloc_ready !== 0 || o_wb_vd !== 5'd8 || o_count !== 4'd8)
      $display("FAIL full_retire_cyc got v=%b ready=%b vd=%0d cnt=%0d want 1 0 8 8", o_wb_valid, o_alloc_ready, o_wb_vd, o_count); else passes++;
    step();
    i_wb_ready = 0;
    #1;
    checks++; if (o_alloc_ready !== 1 || o_alloc_idx !== 3'd0 || o_count !== 4'd7)
      $display("FAIL full_after_retire got ready=%b idx=%0d cnt=%0d want 1 0 7", o_alloc_ready, o_alloc_idx, o_count); else passes++;
    step();
    i_alloc_valid = 0;
    checks++; if (o_count !== 4'd8 || o_alloc_ready !== 0 || o_alloc_idx !== 3'd1)
      $display("FAIL full_wrap_alloc got cnt=%0d ready=%b idx=%0d want 8 0 1", o_count, o_alloc_ready, o_alloc_idx); else passes++;
  endtask

  task automatic test_stall();
    do_reset();
    alloc1(5, 1);
    alloc1(6, 0);
    fill1(0, 7);
    fill1(1, 8);
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (o_wb_valid !== 1 || o_wb_data !== mkd(7) || o_wb_vd !== 5'd5 || o_wb_last !== 1)
        $display("FAIL stall_hold%0d got v=%b vd=%0d want v=1 vd=5", i, o_wb_valid, o_wb_vd); else passes++;
      step();
    end
    i_wb_ready = 1;
    step();
    i_wb_ready = 0;
    checks++; if (o_count !== 4'd1 || o_wb_valid !== 1 || o_wb_vd !== 5'd6 || o_wb_data !== mkd(8))
      $display("FAIL stall_one_retire got cnt=%0d v=%b vd=%0d want 1 1 6", o_count, o_wb_valid, o_wb_vd); else passes++;
  endtask

  task automatic test_err();
    do_reset();
    alloc1(7, 0);
    fill1(0, 11);
    checks++; if (o_err !== 0) $display("FAIL err_clean got=%b want=0", o_err); else passes++;
    fill1(0, 12);
    checks++; if (o_err !== 1) $display("FAIL err_refill got=%b want=1", o_err); else passes++;
    checks++; if (o_wb_data !== mkd(11) || o_wb_mask !== mkm(11))
      $display("FAIL err_data_kept got=%0h want=%0h", o_wb_data[31:0], mkd(11) & 512'hFFFF_FFFF); else passes++;
    step(); step(); step();
    checks++; if (o_err !== 1) $display("FAIL err_sticky got=%b want=1", o_err); else passes++;
    do_reset();
    checks++; if (o_err !== 0) $display("FAIL err_rst_clear got=%b want=0", o_err); else passes++;
    fill1(3, 13);
    checks++; if (o_err !== 1 || o_count !== 4'd0)
      $display("FAIL err_empty_fill got err=%b cnt=%0d want 1 0", o_err, o_count); else passes++;
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 5; i++) alloc1(i + 1, 0);
    fill1(1, 14);
    fill1(3, 15);
    checks++; if (o_count !== 4'd5) $display("FAIL fl_pre_count got=%0d want=5", o_count); else passes++;
    i_flush = 1; i_alloc_valid = 1; i_alloc_vd = 5'd30;
    i_ld_valid = 1; i_ld_idx = 3'd2; i_ld_data = mkd(16); i_ld_mask = mkm(16);
    step();
    idle();
    #1;
    checks++; if (o_count !== 4'd0 || o_lq_empty !== 1 || o_wb_valid !== 0 || o_alloc_ready !== 1)
      $display("FAIL fl_cleared got cnt=%0d empty=%b v=%b ready=%b want 0 1 0 1", o_count, o_lq_empty, o_wb_valid, o_alloc_ready); else passes++;
    checks++; if (o_alloc_idx !== 3'd0 || o_err !== 0)
      $display("FAIL fl_idx_err got idx=%0d err=%b want 0 0", o_alloc_idx, o_err); else passes++;
    alloc1(9, 0);
    checks++; if (o_count !== 4'd1 || o_wb_valid !== 0 || o_alloc_idx !== 3'd1)
      $display("FAIL fl_realloc got cnt=%0d v=%b idx=%0d want 1 0 1", o_count, o_wb_valid, o_alloc_idx); else passes++;
  endtask

  task automatic test_async_reset();
    do_reset();
    alloc1(1, 0);
    alloc1(2, 1);
    fill1(0, 17);
    i_alloc_valid = 1; i_alloc_vd = 5'd3;
    step();
    #1;
    checks++; if (o_wb_valid !== 1 || o_count !== 4'd3)
      $display("FAIL ar_pre got v=%b cnt=%0d want 1 3", o_wb_valid, o_count); else passes++;
    i_reset = 1;
    #1;
    checks++; if (o_wb_valid !== 0 || o_count !== 4'd0 || o_lq_empty !== 1 || o_alloc_ready !== 1)
      $display("FAIL ar_outputs got v=%b cnt=%0d empty=%b ready=%b want 0 0 1 1", o_wb_valid, o_count, o_lq_empty, o_alloc_ready); else passes++;
    checks++; if (o_wb_data !== '0 || o_wb_vd !== 5'd0 || o_alloc_idx !== 3'd0)
      $display("FAIL ar_fields got vd=%0d idx=%0d want 0 0", o_wb_vd, o_alloc_idx); else passes++;
    idle();
    step();
    i_reset = 0;
  endtask

`ifdef TT_VPU_LQ_BYPASS_EN
  task automatic test_bypass();
    do_reset();
    alloc1(4, 1);
    i_wb_ready = 1;
    i_ld_valid = 1; i_ld_idx = 3'd0; i_ld_data = mkd(21); i_ld_mask = mkm(21);
    #1;
    checks++; if (o_wb_valid !== 1 || o_wb_data !== mkd(21) || o_wb_mask !== mkm(21) || o_wb_vd !== 5'd4)
      $display("FAIL byp_same_cycle got v=%b vd=%0d want 1 4", o_wb_valid, o_wb_vd); else passes++;
    step();
    idle();
    #1;
    checks++; if (o_count !== 4'd0 || o_wb_valid !== 0)
      $display("FAIL byp_retired got cnt=%0d v=%b want 0 0", o_count, o_wb_valid); else passes++;
  endtask
`endif

  initial begin
    test_reset();
    test_in_order();
    test_full();
    test_stall();
    test_err();
    test_flush();
    test_async_reset();
`ifdef TT_VPU_LQ_BYPASS_EN
    test_bypass();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
